// File: rtl/pipo_arb_pkg.sv
// rtl/pipo_arb_pkg.sv - shared types and constants for the round-robin PIPO arbiter
//
// Purpose : arbiter state encoding, default parameter values, hold counter
//           width and the owner-index width helper.
// Ports   : none (package).
package pipo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } arb_state_t;

   localparam int DEF_NREQ        = 4;
   localparam int DEF_WIDTH       = 4;
   localparam int DEF_HOLD_CYCLES = 2;
   localparam int HOLD_CNT_W      = 4;

   // Owner index width; never below one bit so the port always exists.
   function automatic int owner_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pipo_rr_pick.sv
// rtl/pipo_rr_pick.sv - combinational round-robin picker
//
// Purpose : choose the first requester at or after last_winner+1 (mod NREQ),
//           searching upward with wrap-around.
// Ports   : req         in  NREQ     request vector
//           last_winner in  OWNER_W  index granted most recently
//           onehot      out NREQ     one-hot winner (zero when none)
//           idx         out OWNER_W  winner index (zero when none)
//           any         out 1        at least one request present
module pipo_rr_pick #(
   parameter int NREQ    = pipo_arb_pkg::DEF_NREQ,
   parameter int OWNER_W = pipo_arb_pkg::owner_width(NREQ)
) (
   input  logic [NREQ-1:0]    req,
   input  logic [OWNER_W-1:0] last_winner,
   output logic [NREQ-1:0]    onehot,
   output logic [OWNER_W-1:0] idx,
   output logic               any
);

   always_comb begin
      int cand;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = 0;
      // Offsets 1..NREQ put the previous winner last in priority.
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(last_winner) + k) % NREQ;
         if (!any && req[cand]) begin
            onehot[cand] = 1'b1;
            idx          = OWNER_W'(cand);
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipo_rr_arbiter.sv
// rtl/pipo_rr_arbiter.sv - round-robin owner of a shared PIPO holding register
//
// Purpose : grant one requester at a time, load its data word into the shared
//           register, tag it with the owner and lock it for HOLD_CYCLES.
// Ports   : clk      in  1           clock, rising edge
//           rstn     in  1           asynchronous reset, active HIGH
//           req      in  NREQ        level requests, held until granted
//           din      in  NREQ*WIDTH  requester data, slice i = din[i*WIDTH +: WIDTH]
//           gnt      out NREQ        registered one-hot grant, one cycle per load
//           q        out WIDTH       shared register contents
//           q_owner  out OWNER_W     requester whose data is in q
//           q_valid  out 1           q loaded since reset
//           busy     out 1           GRANT or HOLD in progress
module pipo_rr_arbiter #(
   parameter int NREQ        = pipo_arb_pkg::DEF_NREQ,
   parameter int WIDTH       = pipo_arb_pkg::DEF_WIDTH,
   parameter int HOLD_CYCLES = pipo_arb_pkg::DEF_HOLD_CYCLES,
   parameter int OWNER_W     = pipo_arb_pkg::owner_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] din,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic [OWNER_W-1:0]    q_owner,
   output logic                  q_valid,
   output logic                  busy
);

   import pipo_arb_pkg::*;

   // HOLD is left on the edge where the counter reaches HOLD_CYCLES-1.
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_CNT_W-1:0] HOLD_SAT  = HOLD_CNT_W'(HOLD_CYCLES);

   arb_state_t            state;
   arb_state_t            state_n;
   logic [NREQ-1:0]       gnt_n;
   logic [NREQ-1:0]       pick_onehot;
   logic [OWNER_W-1:0]    pick_idx;
   logic                  pick_any;
   logic [OWNER_W-1:0]    win_idx;
   logic [OWNER_W-1:0]    last_winner;
   logic [HOLD_CNT_W-1:0] hold_cnt;

   pipo_rr_pick #(
      .NREQ    (NREQ),
      .OWNER_W (OWNER_W)
   ) u_pick (
      .req         (req),
      .last_winner (last_winner),
      .onehot      (pick_onehot),
      .idx         (pick_idx),
      .any         (pick_any)
   );

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = '0;
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               state_n = GRANT;
               gnt_n   = pick_onehot;
            end
         end
         GRANT: begin
            state_n = (HOLD_CYCLES > 0) ? HOLD : IDLE;
         end
         HOLD: begin
            if (hold_cnt >= HOLD_LAST) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         gnt         <= '0;
         win_idx     <= '0;
         last_winner <= OWNER_W'(NREQ - 1);
         hold_cnt    <= '0;
         q           <= '0;
         q_owner     <= '0;
         q_valid     <= 1'b0;
      end else begin
         gnt <= gnt_n;
         if (state == IDLE && pick_any) begin
            win_idx <= pick_idx;
         end
         // The requester keeps din stable through the GRANT cycle, so the
         // load happens at its closing edge.
         if (state == GRANT) begin
            q           <= din[int'(win_idx)*WIDTH +: WIDTH];
            q_owner     <= win_idx;
            q_valid     <= 1'b1;
            last_winner <= win_idx;
            hold_cnt    <= '0;
         end else if (state == HOLD && hold_cnt < HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// tb/tb_pipo_rr_arbiter.sv - self-checking bench for pipo_rr_arbiter
module tb_pipo_rr_arbiter;

   localparam int HOLD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req  = '0;
   logic [15:0] din  = '0;
   logic [3:0]  req0 = '0;
   logic [15:0] din0 = '0;
   logic [3:0]  gnt, q, gnt0, q0;
   logic [1:0]  q_owner, q_owner0;
   logic        q_valid, busy, q_valid0, busy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipo_rr_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(HOLD), .OWNER_W(2)) dut (
      .clk(clk), .rstn(rst), .req(req), .din(din), .gnt(gnt), .q(q),
      .q_owner(q_owner), .q_valid(q_valid), .busy(busy)
   );

   pipo_rr_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(0), .OWNER_W(2)) dut0 (
      .clk(clk), .rstn(rst), .req(req0), .din(din0), .gnt(gnt0), .q(q0),
      .q_owner(q_owner0), .q_valid(q_valid0), .busy(busy0)
   );

   typedef struct packed {
      logic [3:0]  req;
      logic [15:0] din;
      logic [3:0]  gnt;
      logic [3:0]  q;
      logic [1:0]  owner;
      logic        valid;
      logic        busy;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(input logic [3:0] r, input logic [15:0] d, input logic [3:0] g,
                               input logic [3:0] qq, input logic [1:0] o, input logic v,
                               input logic b);
      vec_t x;
      x.req = r; x.din = d; x.gnt = g; x.q = qq; x.owner = o; x.valid = v; x.busy = b;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: transaction timing by edge number. A grant taken at
   // edge g loads at g+1, keeps the arbiter busy through edge g+HOLD and the
   // next request is sampled at edge g+2+HOLD.
   int         m_k, m_nxt, m_ptr, m_win;
   bit         m_pend;
   logic [3:0] m_gnt, m_q;
   int         m_owner;
   bit         m_valid, m_busy;

   task automatic model_reset();
      m_k = 0; m_nxt = 0; m_ptr = 3; m_win = 0; m_pend = 0;
      m_gnt = '0; m_q = '0; m_owner = 0; m_valid = 0; m_busy = 0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [15:0] d);
      bit found;
      m_gnt = '0;
      if (m_pend) begin
         m_q = d[m_win*4 +: 4];
         m_owner = m_win;
         m_valid = 1;
         m_ptr = m_win;
         m_pend = 0;
      end
      if (m_k >= m_nxt && r != 4'b0) begin
         found = 0;
         for (int s = 1; s <= 4; s++) begin
            if (!found && r[(m_ptr + s) % 4]) begin
               m_win = (m_ptr + s) % 4;
               found = 1;
            end
         end
         m_gnt  = 4'(1 << m_win);
         m_pend = 1;
         m_nxt  = m_k + 2 + HOLD;
      end
      m_busy = (m_k < m_nxt - 1);
      m_k++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0; din = '0; req0 = '0; din0 = '0;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_grant(input int maxc, output logic [3:0] g);
      g = '0;
      for (int i = 0; i < maxc && g == 4'b0; i++) begin
         tick();
         g = gnt;
      end
      checks++;
      if (g == 4'b0) begin
         errors++;
         $display("FAIL wait_grant: no grant within %0d cycles, got %0h", maxc, g);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] g;
      logic [3:0] prev_g;
      logic [3:0] e0;

      vecs[0]  = mk(4'hF, 16'h4321, 4'h1, 4'h0, 2'd0, 1'b0, 1'b1);
      vecs[1]  = mk(4'hF, 16'h4321, 4'h0, 4'h1, 2'd0, 1'b1, 1'b1);
      vecs[2]  = mk(4'hF, 16'h4321, 4'h0, 4'h1, 2'd0, 1'b1, 1'b1);
      vecs[3]  = mk(4'hF, 16'h4321, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0);
      vecs[4]  = mk(4'hF, 16'h4321, 4'h2, 4'h1, 2'd0, 1'b1, 1'b1);
      vecs[5]  = mk(4'hF, 16'h4321, 4'h0, 4'h2, 2'd1, 1'b1, 1'b1);
      vecs[6]  = mk(4'hF, 16'h4321, 4'h0, 4'h2, 2'd1, 1'b1, 1'b1);
      vecs[7]  = mk(4'hF, 16'h4321, 4'h0, 4'h2, 2'd1, 1'b1, 1'b0);
      vecs[8]  = mk(4'hF, 16'h4321, 4'h4, 4'h2, 2'd1, 1'b1, 1'b1);
      vecs[9]  = mk(4'hF, 16'h4321, 4'h0, 4'h3, 2'd2, 1'b1, 1'b1);
      vecs[10] = mk(4'hF, 16'h4321, 4'h0, 4'h3, 2'd2, 1'b1, 1'b1);
      vecs[11] = mk(4'hF, 16'h4321, 4'h0, 4'h3, 2'd2, 1'b1, 1'b0);
      vecs[12] = mk(4'hF, 16'h4321, 4'h8, 4'h3, 2'd2, 1'b1, 1'b1);
      vecs[13] = mk(4'hF, 16'h4321, 4'h0, 4'h4, 2'd3, 1'b1, 1'b1);
      vecs[14] = mk(4'hF, 16'h4321, 4'h0, 4'h4, 2'd3, 1'b1, 1'b1);
      vecs[15] = mk(4'hF, 16'h4321, 4'h0, 4'h4, 2'd3, 1'b1, 1'b0);
      vecs[16] = mk(4'hF, 16'h4321, 4'h1, 4'h4, 2'd3, 1'b1, 1'b1);
      vecs[17] = mk(4'hF, 16'h4321, 4'h0, 4'h1, 2'd0, 1'b1, 1'b1);
      vecs[18] = mk(4'h0, 16'h0000, 4'h0, 4'h1, 2'd0, 1'b1, 1'b1);
      vecs[19] = mk(4'h0, 16'h0000, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0);
      vecs[20] = mk(4'h4, 16'h0A00, 4'h4, 4'h1, 2'd0, 1'b1, 1'b1);
      vecs[21] = mk(4'h4, 16'h0A00, 4'h0, 4'hA, 2'd2, 1'b1, 1'b1);
      vecs[22] = mk(4'h0, 16'h0000, 4'h0, 4'hA, 2'd2, 1'b1, 1'b1);
      vecs[23] = mk(4'h0, 16'h0000, 4'h0, 4'hA, 2'd2, 1'b1, 1'b0);
      vecs[24] = mk(4'h0, 16'h0000, 4'h0, 4'hA, 2'd2, 1'b1, 1'b0);

      // Reset state.
      do_reset();
      chk("rst.gnt", 32'(gnt), 32'h0);
      chk("rst.q", 32'(q), 32'h0);
      chk("rst.owner", 32'(q_owner), 32'h0);
      chk("rst.valid", 32'(q_valid), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);

      // Table: all requesting continuously, then a single requester.
      for (int i = 0; i < 25; i++) begin
         req = vecs[i].req;
         din = vecs[i].din;
         tick();
         chk($sformatf("tbl[%0d].gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         chk($sformatf("tbl[%0d].q", i), 32'(q), 32'(vecs[i].q));
         chk($sformatf("tbl[%0d].owner", i), 32'(q_owner), 32'(vecs[i].owner));
         chk($sformatf("tbl[%0d].valid", i), 32'(q_valid), 32'(vecs[i].valid));
         chk($sformatf("tbl[%0d].busy", i), 32'(busy), 32'(vecs[i].busy));
      end

      // Reset during GRANT abandons the load.
      do_reset();
      req = 4'b0010;
      din = 16'h0050;
      tick();
      chk("midrst.pre_gnt", 32'(gnt), 32'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst.async_gnt", 32'(gnt), 32'h0);
      chk("midrst.async_busy", 32'(busy), 32'h0);
      tick();
      chk("midrst.gnt", 32'(gnt), 32'h0);
      chk("midrst.q", 32'(q), 32'h0);
      chk("midrst.valid", 32'(q_valid), 32'h0);
      rst = 1'b0;
      req = 4'b1100;
      din = 16'h3C00;
      tick();
      chk("midrst.first_gnt", 32'(gnt), 32'h4);
      tick();
      chk("midrst.first_q", 32'(q), 32'hC);
      chk("midrst.first_owner", 32'(q_owner), 32'h2);
      req = '0;

      // Wrap from last_winner=3, then a request raised only during HOLD.
      do_reset();
      req = 4'b1000;
      din = 16'h8000;
      tick();
      chk("wrap.seed_gnt", 32'(gnt), 32'h8);
      tick();
      chk("wrap.seed_q", 32'(q), 32'h8);
      req = 4'b1001;
      din = 16'h8001;
      wait_grant(8, g);
      chk("wrap.first", 32'(g), 32'h1);
      tick();
      chk("wrap.first_q", 32'(q), 32'h1);
      chk("wrap.first_owner", 32'(q_owner), 32'h0);
      req = 4'b1000;
      wait_grant(8, g);
      chk("wrap.second", 32'(g), 32'h8);
      tick();
      chk("wrap.second_q", 32'(q), 32'h8);
      req = 4'b0010;
      din = 16'h80F0;
      tick();
      tick();
      req = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("holdreq[%0d].gnt", i), 32'(gnt), 32'h0);
      end
      chk("holdreq.q", 32'(q), 32'h8);
      chk("holdreq.owner", 32'(q_owner), 32'h3);

      // HOLD_CYCLES=0 instance: two requesters held high.
      do_reset();
      req0 = 4'b0011;
      din0 = 16'h0097;
      for (int k = 0; k < 12; k++) begin
         tick();
         e0 = (k % 2 == 1) ? 4'h0 : (((k / 2) % 2 == 0) ? 4'h1 : 4'h2);
         chk($sformatf("h0[%0d].gnt", k), 32'(gnt0), 32'(e0));
         chk($sformatf("h0[%0d].busy", k), 32'(busy0), 32'(k % 2 == 0));
         if (k % 2 == 1) begin
            chk($sformatf("h0[%0d].q", k), 32'(q0),
                ((((k - 1) / 2) % 2) == 0) ? 32'h7 : 32'h9);
         end
      end
      chk("h0.valid", 32'(q_valid0), 32'h1);
      chk("h0.owner", 32'(q_owner0), 32'h1);
      req0 = '0;

      // Randomized requesters against the model.
      do_reset();
      prev_g = '0;
      for (int n = 0; n < 500; n++) begin
         model_edge(req, din);
         tick();
         chk("rnd.gnt", 32'(gnt), 32'(m_gnt));
         chk("rnd.q", 32'(q), 32'(m_q));
         chk("rnd.owner", 32'(q_owner), 32'(m_owner));
         chk("rnd.valid", 32'(q_valid), 32'(m_valid));
         chk("rnd.busy", 32'(busy), 32'(m_busy));
         for (int i = 0; i < 4; i++) begin
            if (m_gnt[i]) begin
               req[i] = req[i];
            end else if (prev_g[i]) begin
               req[i] = 1'b0;
               din[i*4 +: 4] = 4'($urandom);
            end else if (!req[i]) begin
               if ($urandom_range(3) == 0) begin
                  req[i] = 1'b1;
                  din[i*4 +: 4] = 4'($urandom);
               end
            end else if ($urandom_range(15) == 0) begin
               req[i] = 1'b0;
            end
         end
         prev_g = m_gnt;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
